// File: rtl/uart_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctrl_pkg
// Purpose  : Shared encodings for the buffered uart sequencer.
// Revision : 1.0
// ============================================================================
package uart_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POLL  = 2'd1,
        S_RX_RD = 2'd2,
        S_TX_WR = 2'd3
    } state_t;

    // Host-visible status register bits
    localparam int ST_TXFULL = 15;
    localparam int ST_RXNE   = 14;
    localparam int ST_OVR    = 13;
    localparam int ST_TXIDLE = 12;

    // Uart core status register bits
    localparam int U_TXBUSY = 15;
    localparam int U_RXFULL = 14;

    localparam logic REG_STAT = 1'b0;
    localparam logic REG_DATA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctrl_if / uart_fifo_ctrl_uart_if
// Purpose  : Host-side and uart-side a0/rnw/cs_b register buses.
// Revision : 1.0
// ============================================================================
interface uart_fifo_ctrl_if;
    logic [15:0] h_din;
    logic [15:0] h_dout;
    logic        h_a0;
    logic        h_rnw;
    logic        h_cs_b;

    modport master (output h_din, h_a0, h_rnw, h_cs_b, input h_dout);
    modport slave  (input h_din, h_a0, h_rnw, h_cs_b, output h_dout);
endinterface

interface uart_fifo_ctrl_uart_if;
    logic [15:0] u_din;
    logic [15:0] u_dout;
    logic        u_a0;
    logic        u_rnw;
    logic        u_cs_b;

    modport master (output u_din, u_a0, u_rnw, u_cs_b, input u_dout);
    modport slave  (input u_din, u_a0, u_rnw, u_cs_b, output u_dout);
endinterface
`default_nettype wire

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : 8-bit synchronous FIFO with combinational head read.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic       clk,
    input  wire logic       reset_b,
    input  wire logic       push,
    input  wire logic       pop,
    input  wire logic [7:0] wdata,
    output logic      [7:0] rdata,
    output logic            full,
    output logic            empty
);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign rdata     = r_mem[r_rptr];
    // A pop on empty is ignored; a push on full is accepted only alongside a real pop
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctrl
// Purpose  : Polls a uart core, buffering RX/TX bytes in FIFOs for the host.
//            Optional irq output with `define UART_FIFO_CTRL_IRQ_EN.
// Revision : 1.0
// ============================================================================
module uart_fifo_ctrl
    import uart_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_b,
    uart_fifo_ctrl_if.slave       host,
    uart_fifo_ctrl_uart_if.master uart
`ifdef UART_FIFO_CTRL_IRQ_EN
    ,
    output logic                  irq
`endif
);
    state_t     r_state;
    state_t     w_next;
    logic       r_ovr;
    logic       w_stat_rd;
    logic       w_data_rd;
    logic       w_data_wr;
    logic       w_rx_push;
    logic       w_rx_drop;
    logic [7:0] w_rx_head;
    logic [7:0] w_tx_head;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_unused_bits;

    assign w_stat_rd = ~host.h_cs_b &  host.h_rnw & (host.h_a0 == REG_STAT);
    assign w_data_rd = ~host.h_cs_b &  host.h_rnw & (host.h_a0 == REG_DATA);
    assign w_data_wr = ~host.h_cs_b & ~host.h_rnw & (host.h_a0 == REG_DATA);
    assign w_rx_push = (r_state == S_RX_RD);
    // A full RX FIFO still takes the byte when the host pops in the same cycle
    assign w_rx_drop = w_rx_push & w_rx_full & ~w_data_rd;
    assign w_unused_bits = ^{host.h_din[15:8], uart.u_dout[13:8]};

    sync_fifo #(.DEPTH(DEPTH), .AW(AW)) rx_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (w_rx_push),
        .pop     (w_data_rd),
        .wdata   (uart.u_dout[7:0]),
        .rdata   (w_rx_head),
        .full    (w_rx_full),
        .empty   (w_rx_empty)
    );

    sync_fifo #(.DEPTH(DEPTH), .AW(AW)) tx_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (w_data_wr),
        .pop     (r_state == S_TX_WR),
        .wdata   (host.h_din[7:0]),
        .rdata   (w_tx_head),
        .full    (w_tx_full),
        .empty   (w_tx_empty)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_rx_drop)      r_ovr <= 1'b1;
            else if (w_stat_rd) r_ovr <= 1'b0;
        end
    end

    always_comb begin
        w_next      = r_state;
        uart.u_cs_b = 1'b1;
        uart.u_rnw  = 1'b1;
        uart.u_a0   = REG_STAT;
        uart.u_din  = 16'h0000;
        case (r_state)
            S_IDLE: w_next = S_POLL;
            S_POLL: begin
                uart.u_cs_b = 1'b0;
                if (uart.u_dout[U_RXFULL])
                    w_next = S_RX_RD;
                else if (!uart.u_dout[U_TXBUSY] && !w_tx_empty)
                    w_next = S_TX_WR;
            end
            S_RX_RD: begin
                uart.u_cs_b = 1'b0;
                uart.u_a0   = REG_DATA;
                w_next      = S_POLL;
            end
            S_TX_WR: begin
                uart.u_cs_b = 1'b0;
                uart.u_rnw  = 1'b0;
                uart.u_a0   = REG_DATA;
                uart.u_din  = {8'h00, w_tx_head};
                w_next      = S_POLL;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        host.h_dout = 16'h0000;
        if (host.h_a0 == REG_DATA) begin
            if (!w_rx_empty) host.h_dout = {8'h00, w_rx_head};
        end else begin
            host.h_dout[ST_TXFULL] = w_tx_full;
            host.h_dout[ST_RXNE]   = ~w_rx_empty;
            host.h_dout[ST_OVR]    = r_ovr;
            host.h_dout[ST_TXIDLE] = w_tx_empty & (r_state != S_TX_WR);
        end
    end

`ifdef UART_FIFO_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) irq <= 1'b0;
        else          irq <= ~w_rx_empty | r_ovr;
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_ctrl
// Purpose  : Scoreboard bench with a behavioural loopback uart register model.
// Revision : 1.0
// ============================================================================
module tb_uart_fifo_ctrl;
    localparam int TX_CLKS = 6;
    localparam int GAP     = 3;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    uart_fifo_ctrl_if      hb();
    uart_fifo_ctrl_uart_if ub();
`ifdef UART_FIFO_CTRL_IRQ_EN
    logic irq;
`endif

    uart_fifo_ctrl #(.DEPTH(16), .AW(4)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .host    (hb),
        .uart    (ub)
`ifdef UART_FIFO_CTRL_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    bit          acc_log[$];   // 1 = uart data write, 0 = uart data read

    // ---------------- uart register model with txd->rxd loopback ----------------
    logic [7:0] rx_q[$];
    int         m_busy;
    int         m_gap;
    logic       m_hold = 1'b0;
    logic       m_rx_full;
    logic [7:0] m_rx_byte;
    logic [7:0] m_tx_byte;
    wire        m_load = ~ub.u_cs_b & ~ub.u_rnw & ub.u_a0;
    wire        m_rd   = ~ub.u_cs_b &  ub.u_rnw & ub.u_a0;

    assign ub.u_dout = ub.u_a0 ? {8'h00, m_rx_byte}
                               : {((m_busy != 0) | m_hold), m_rx_full, 14'h0000};

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m_busy <= 0; m_gap <= 0; m_rx_full <= 1'b0; m_rx_byte <= 8'h00; m_tx_byte <= 8'h00;
            rx_q.delete();
        end else begin
            if (m_busy != 0) m_busy <= m_busy - 1;
            if (m_busy == 1) rx_q.push_back(m_tx_byte);
            if (m_load) begin m_busy <= TX_CLKS; m_tx_byte <= ub.u_din[7:0]; end
            if (m_gap != 0) m_gap <= m_gap - 1;
            if (m_rd) m_rx_full <= 1'b0;
            if (m_gap == 0 && !m_rx_full && rx_q.size() > 0) begin
                m_rx_full <= 1'b1;
                m_rx_byte <= rx_q.pop_front();
                m_gap     <= GAP;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor: pops scoreboards as the DUT presents outputs ----------------
    always @(negedge clk) begin
        if (reset_b) begin
            if (!hb.h_cs_b && hb.h_rnw) begin
                if (exp_rd.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL host_rd_unexpected: got %h expected none", hb.h_dout);
                end else check("host_rd", hb.h_dout, exp_rd.pop_front());
            end
            if (!ub.u_cs_b && ub.u_a0) acc_log.push_back(~ub.u_rnw);
            if (m_load) begin
                if (exp_tx.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL uart_load_unexpected: got %h expected none", ub.u_din);
                end else check("uart_load", ub.u_din, {8'h00, exp_tx.pop_front()});
            end
        end
    end

    // ---------------- host bus tasks ----------------
    task automatic host_idle();
        hb.h_cs_b = 1'b1; hb.h_rnw = 1'b1; hb.h_a0 = 1'b0; hb.h_din = 16'h0000;
    endtask

    task automatic host_wr(input logic [7:0] d);
        @(posedge clk); #1;
        hb.h_cs_b = 1'b0; hb.h_rnw = 1'b0; hb.h_a0 = 1'b1; hb.h_din = {8'h00, d};
        @(posedge clk); #1;
        host_idle();
    endtask

    task automatic host_rd(input logic a0, input logic [15:0] exp);
        @(posedge clk); #1;
        exp_rd.push_back(exp);
        hb.h_cs_b = 1'b0; hb.h_rnw = 1'b1; hb.h_a0 = a0;
        @(posedge clk); #1;
        host_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        host_idle();

        // 1: reset state and IDLE -> POLL
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_u_cs_b", {15'h0, ub.u_cs_b}, 16'h0001);
        check("rst_uart_ctl", {13'h0, ub.u_rnw, ub.u_a0, 1'b0}, 16'h0004);
        check("rst_u_din", ub.u_din, 16'h0000);
        check("rst_status", hb.h_dout, 16'h1000);
`ifdef UART_FIFO_CTRL_IRQ_EN
        check("rst_irq", {15'h0, irq}, 16'h0000);
`endif
        @(posedge clk); #1 reset_b = 1'b1;
        @(negedge clk);
        check("idle_u_cs_b", {15'h0, ub.u_cs_b}, 16'h0001);
        @(negedge clk);
        check("poll_ctl", {13'h0, ub.u_cs_b, ub.u_rnw, ub.u_a0}, 16'h0002);

        // 2: single byte, TX latency and loopback
        exp_tx.push_back(8'h41);
        host_wr(8'h41);
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (m_load) seen = 1'b1;
        end
        check("tx_latency", {15'h0, seen}, 16'h0001);
        repeat (20) @(posedge clk);
        host_rd(1'b0, 16'h5000);
        host_rd(1'b1, 16'h0041);
        host_rd(1'b0, 16'h1000);

        // 3: fill TX FIFO while uart is held busy, overflow write, then loop back all
        m_hold = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            exp_tx.push_back(8'(i));
            hb.h_cs_b = 1'b0; hb.h_rnw = 1'b0; hb.h_a0 = 1'b1; hb.h_din = 16'(i);
            @(posedge clk); #1;
        end
        host_idle();
        host_rd(1'b0, 16'h8000);
        host_wr(8'h10);
        host_rd(1'b0, 16'h8000);
        m_hold = 1'b0;
        repeat (300) @(posedge clk);
        for (int i = 0; i < 16; i++) host_rd(1'b1, 16'(i));
        host_rd(1'b0, 16'h1000);

        // 4: 17 injected frames with no reads -> 16 kept, overrun flagged then cleared
        for (int i = 0; i < 17; i++) rx_q.push_back(8'h80 + 8'(i));
        repeat (150) @(posedge clk);
        host_rd(1'b0, 16'h7000);
        host_rd(1'b0, 16'h5000);
        for (int i = 0; i < 16; i++) host_rd(1'b1, 16'h0080 + 16'(i));
        host_rd(1'b0, 16'h1000);
        host_rd(1'b1, 16'h0000);

        // 5: RX drain wins over a ready TX refill
        repeat (10) @(posedge clk);
        acc_log.delete();
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'hA5);
        host_wr(8'h5A);
        host_wr(8'hA5);
        repeat (40) @(posedge clk);
        if (acc_log.size() == 4)
            check("access_order", {12'h0, acc_log[0], acc_log[1], acc_log[2], acc_log[3]}, 16'h000A);
        else
            check("access_count", 16'(acc_log.size()), 16'h0004);
        host_rd(1'b1, 16'h005A);
        host_rd(1'b1, 16'h00A5);

        // 6: reset during TX_WR drops everything
        m_hold = 1'b1;
        exp_tx.push_back(8'h55);
        host_wr(8'h55);
        host_wr(8'h66);
        m_hold = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (m_load) seen = 1'b1;
        end
        check("tx_wr_reached", {15'h0, seen}, 16'h0001);
        #2 reset_b = 1'b0;
        #1;
        check("async_rst_u_cs_b", {15'h0, ub.u_cs_b}, 16'h0001);
        check("async_rst_status", hb.h_dout, 16'h1000);
`ifdef UART_FIFO_CTRL_IRQ_EN
        check("async_rst_irq", {15'h0, irq}, 16'h0000);
`endif
        repeat (2) @(posedge clk);
        #1 reset_b = 1'b1;
        rx_q.push_back(8'h77);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (hb.h_dout[14]) seen = 1'b1;
        end
        check("rx_after_reset", {15'h0, seen}, 16'h0001);
`ifdef UART_FIFO_CTRL_IRQ_EN
        check("irq_lag0", {15'h0, irq}, 16'h0000);
        @(negedge clk);
        check("irq_lag1", {15'h0, irq}, 16'h0001);
`endif
        host_rd(1'b1, 16'h0077);
        repeat (30) @(posedge clk);
        host_rd(1'b0, 16'h1000);

        repeat (5) @(posedge clk);
        check("exp_tx_left", 16'(exp_tx.size()), 16'h0000);
        check("exp_rd_left", 16'(exp_rd.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
